// File: rtl/demux1to4_stream.sv
`default_nettype none
// ============================================================================
//  Module   : demux1to4_stream
//  Purpose  : Registered 1-to-4 valid/ready stream demultiplexer. A single
//             holding register steers each beat to the channel named by its
//             2-bit tag. Define DEMUX1TO4_STREAM_CNT_EN to add per-channel
//             saturating beat counters on port beat_cnt.
//  Revision : 1.0  initial release
// ============================================================================
module demux1to4_stream #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_sel,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_sel
`ifdef DEMUX1TO4_STREAM_CNT_EN
  ,
  output logic [63:0]       beat_cnt
`endif
);

  localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        sel_q,  sel_d;
  logic              full_q, full_d;
  logic              out_fire;
  logic              in_fire;

  // Only the ready bit of the held beat's channel matters.
  always_comb begin
    out_fire = full_q & out_ready[sel_q];
    in_ready = ~full_q | out_fire;
    in_fire  = in_valid & in_ready;
  end

  always_comb begin
    data_d = data_q;
    sel_d  = sel_q;
    full_d = full_q;
    if (in_fire) begin
      data_d = in_data;
      sel_d  = in_sel;
      full_d = 1'b1;
    end else if (out_fire) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      sel_q  <= 2'd0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      sel_q  <= sel_d;
      full_q <= full_d;
    end
  end

  always_comb begin
    out_valid = full_q ? (4'b0001 << sel_q) : 4'b0000;
    out_data  = data_q;
    out_sel   = sel_q;
  end

`ifdef DEMUX1TO4_STREAM_CNT_EN
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cnt
      logic [15:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (out_fire && (sel_q == gi[1:0]) && (cnt_q != C_CNT_MAX)) begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= 16'd0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign beat_cnt[16*gi +: 16] = cnt_q;
    end
  endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux1to4_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux1to4_stream
//  Purpose  : Self-checking bench for demux1to4_stream: directed scenarios
//             with literal expectations plus randomized traffic compared
//             every cycle against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_demux1to4_stream;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_sel;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_sel;
`ifdef DEMUX1TO4_STREAM_CNT_EN
  logic [63:0]       beat_cnt;
`endif

  demux1to4_stream #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
`ifdef DEMUX1TO4_STREAM_CNT_EN
    ,
    .beat_cnt  (beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the beats accepted but not yet delivered, in order,
  // plus a delivered-beat tally per destination.
  typedef struct {
    logic [DATA_W-1:0] d;
    logic [1:0]        s;
  } beat_t;

  beat_t       mq[$];
  int unsigned mcnt[4];

  always @(posedge clk) begin
    bit    ofire;
    bit    ifire;
    beat_t b;
    if (rst) begin
      mq.delete();
      for (int i = 0; i < 4; i++) mcnt[i] = 0;
    end else begin
      ofire = (mq.size() != 0) && out_ready[mq[0].s];
      ifire = in_valid && ((mq.size() == 0) || ofire);
      if (ofire) begin
        if (mcnt[mq[0].s] < 65535) mcnt[mq[0].s]++;
        void'(mq.pop_front());
      end
      if (ifire) begin
        b.d = in_data;
        b.s = in_sel;
        mq.push_back(b);
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] ev;
    logic       er;
    if (chk_en) begin
      ev = (mq.size() != 0) ? (4'b0001 << mq[0].s) : 4'b0000;
      er = (mq.size() == 0) || out_ready[mq[0].s];
      chk("model_out_valid", {60'd0, out_valid}, {60'd0, ev});
      chk("model_in_ready", {63'd0, in_ready}, {63'd0, er});
      if (mq.size() != 0) begin
        chk("model_out_data", {56'd0, out_data}, {56'd0, mq[0].d});
        chk("model_out_sel", {62'd0, out_sel}, {62'd0, mq[0].s});
      end
`ifdef DEMUX1TO4_STREAM_CNT_EN
      for (int i = 0; i < 4; i++)
        chk("model_beat_cnt", {48'd0, beat_cnt[16*i +: 16]}, {48'd0, mcnt[i][15:0]});
`endif
    end
  end

  // Apply inputs for one cycle; returns just after the following falling edge.
  task automatic cyc(input logic v, input logic [1:0] s, input logic [7:0] d, input logic [3:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 2'd0, 8'h00, 4'b0000);
    cyc(1'b0, 2'd0, 8'h00, 4'b0000);
    rst = 1'b0;
  endtask

  logic [1:0] seq_sel [6];

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = 4'b0000;
    do_reset();
    chk_en = 1'b1;

    // Reset state
    chk("rst_out_valid", {60'd0, out_valid}, 64'h0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'h1);
    chk("rst_out_data", {56'd0, out_data}, 64'h0);
    chk("rst_out_sel", {62'd0, out_sel}, 64'h0);

    // Single beat held under stall, then drained
    cyc(1'b1, 2'd1, 8'h3C, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      chk("stall_out_valid", {60'd0, out_valid}, 64'h2);
      chk("stall_out_data", {56'd0, out_data}, 64'h3C);
      chk("stall_in_ready", {63'd0, in_ready}, 64'h0);
      if (k < 2) cyc(1'b0, 2'd3, 8'hEE, 4'b0000);
    end
    out_ready = 4'b0010;
    #1;
    chk("drain_in_ready", {63'd0, in_ready}, 64'h1);
    cyc(1'b0, 2'd0, 8'h00, 4'b0010);
    chk("drain_out_valid", {60'd0, out_valid}, 64'h0);

    // Full-rate streaming with a changing destination
    seq_sel[0] = 2'd0; seq_sel[1] = 2'd1; seq_sel[2] = 2'd2;
    seq_sel[3] = 2'd3; seq_sel[4] = 2'd3; seq_sel[5] = 2'd0;
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, seq_sel[k], 8'h10 + 8'(k), 4'b1111);
      chk("stream_out_valid", {60'd0, out_valid}, {60'd0, 4'b0001 << seq_sel[k]});
      chk("stream_out_data", {56'd0, out_data}, {56'd0, 8'h10 + 8'(k)});
      chk("stream_in_ready", {63'd0, in_ready}, 64'h1);
    end
    cyc(1'b0, 2'd0, 8'h00, 4'b1111);
    chk("stream_end_valid", {60'd0, out_valid}, 64'h0);

    // Ready on the wrong channels must not drain
    cyc(1'b1, 2'd3, 8'h5A, 4'b0111);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 2'd1, 8'h00, 4'b0111);
      chk("wrong_ch_valid", {60'd0, out_valid}, 64'h8);
      chk("wrong_ch_in_ready", {63'd0, in_ready}, 64'h0);
    end
    cyc(1'b0, 2'd0, 8'h00, 4'b1000);
    chk("right_ch_drain", {60'd0, out_valid}, 64'h0);

    // Simultaneous drain and accept
    cyc(1'b1, 2'd0, 8'h11, 4'b0000);
    chk("simul_pre_valid", {60'd0, out_valid}, 64'h1);
    cyc(1'b1, 2'd2, 8'h77, 4'b0001);
    chk("simul_out_valid", {60'd0, out_valid}, 64'h4);
    chk("simul_out_data", {56'd0, out_data}, 64'h77);
    cyc(1'b0, 2'd0, 8'h00, 4'b1111);

    // Reset during a stall discards the held beat
    cyc(1'b1, 2'd2, 8'hA5, 4'b0000);
    chk("pre_rst_valid", {60'd0, out_valid}, 64'h4);
    rst = 1'b1;
    cyc(1'b0, 2'd0, 8'h00, 4'b0000);
    rst = 1'b0;
    chk("stall_rst_valid", {60'd0, out_valid}, 64'h0);
    chk("stall_rst_in_ready", {63'd0, in_ready}, 64'h1);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = 4'b1111;
      cyc(1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom), r);
    end
    cyc(1'b0, 2'd0, 8'h00, 4'b1111);

`ifdef DEMUX1TO4_STREAM_CNT_EN
    do_reset();
    chk("cnt_rst", beat_cnt, 64'h0);
    for (int k = 0; k < 5; k++) cyc(1'b1, 2'd2, 8'(k), 4'b1111);
    cyc(1'b1, 2'd0, 8'hC0, 4'b1111);
    cyc(1'b0, 2'd0, 8'h00, 4'b1111);
    chk("cnt_slice2", {48'd0, beat_cnt[47:32]}, 64'd5);
    chk("cnt_slice0", {48'd0, beat_cnt[15:0]}, 64'd1);
    chk("cnt_slice1", {48'd0, beat_cnt[31:16]}, 64'd0);
    chk("cnt_slice3", {48'd0, beat_cnt[63:48]}, 64'd0);
    // Drive slice 1 past its maximum to show saturation
    for (int k = 0; k < 65537; k++) cyc(1'b1, 2'd1, 8'(k), 4'b1111);
    cyc(1'b0, 2'd0, 8'h00, 4'b1111);
    chk("cnt_saturate", {48'd0, beat_cnt[31:16]}, 64'hFFFF);
`endif

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
